// File: rtl/operand_packer_if.sv
// Handshake bundle between the operand stream source, the packer and the adder tree.
// master = stream source / vector consumer side, slave = operand_packer.
interface operand_packer_if #(
    parameter int W = 16,
    parameter int L = 128
);
    logic                     clear;
    logic                     in_valid;
    logic                     in_ready;
    logic [W-1:0]             in_data;
    logic                     in_last;
    logic                     bias_load;
    logic [W-1:0]             bias_in;
    logic                     out_valid;
    logic                     out_ready;
    logic [W*L-1:0]           A_out;
    logic [W-1:0]             Bias_out;
    logic                     en_adder_tree;
    logic [$clog2(L+1)-1:0]   fill_count;

    modport master (
        output clear, in_valid, in_data, in_last, bias_load, bias_in, out_ready,
        input  in_ready, out_valid, A_out, Bias_out, en_adder_tree, fill_count
    );

    modport slave (
        input  clear, in_valid, in_data, in_last, bias_load, bias_in, out_ready,
        output in_ready, out_valid, A_out, Bias_out, en_adder_tree, fill_count
    );
endinterface

// File: rtl/operand_packer.sv
// Serial-to-parallel operand packer: collects L W-bit words plus a bias into one vector for the adder tree.
// Define OPERAND_PACKER_PAD_EN to let in_last end a vector early and zero the remaining lanes.
module operand_packer #(
    parameter int W = 16,
    parameter int L = 128
) (
    input  logic             clk,
    input  logic             rst_n,
    operand_packer_if.slave  bus
);
    localparam int IW = (L > 1) ? $clog2(L) : 1;
    localparam int CW = $clog2(L + 1);

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [CW-1:0]   fill_q, fill_d;
    logic [W-1:0]    bias_q;
    logic            accept;
    logic            bias_we;
    logic            last_flag;
    logic            pad_accept;

`ifdef OPERAND_PACKER_PAD_EN
    assign last_flag = bus.in_last;
`else
    logic unused_in_last;
    assign unused_in_last = bus.in_last;
    assign last_flag      = 1'b0;
`endif

    assign pad_accept = accept & last_flag;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        fill_d  = fill_q;
        accept  = 1'b0;
        bias_we = 1'b0;
        // clear wins over any accept, bias capture or hand-off in the same cycle
        if (bus.clear) begin
            state_d = FILL;
            idx_d   = '0;
            fill_d  = '0;
        end else begin
            case (state_q)
                FILL: begin
                    bias_we = bus.bias_load;
                    if (bus.in_valid) begin
                        accept = 1'b1;
                        fill_d = fill_q + 1'b1;
                        if ((idx_q == IW'(L - 1)) || last_flag) begin
                            state_d = HOLD;
                            idx_d   = '0;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        state_d = FILL;
                        fill_d  = '0;
                    end
                end
                default: begin
                    state_d = FILL;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FILL;
            idx_q   <= '0;
            fill_q  <= '0;
            bias_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            fill_q  <= fill_d;
            if (bias_we) begin
                bias_q <= bus.bias_in;
            end
        end
    end

    // Each lane is written only by the accept that targets it; a padded finish zeroes the lanes above.
    for (genvar gi = 0; gi < L; gi++) begin : g_lane
        logic [W-1:0] lane_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                lane_q <= '0;
            end else if (accept && (idx_q == IW'(gi))) begin
                lane_q <= bus.in_data;
            end else if (pad_accept && (idx_q < IW'(gi))) begin
                lane_q <= '0;
            end
        end

        assign bus.A_out[gi*W +: W] = lane_q;
    end

    assign bus.in_ready      = (state_q == FILL);
    assign bus.out_valid     = (state_q == HOLD);
    assign bus.en_adder_tree = (state_q == HOLD);
    assign bus.fill_count    = fill_q;
    assign bus.Bias_out      = bias_q;
endmodule

// File: tb/tb_operand_packer.sv
// Self-checking bench for operand_packer: directed scenarios plus randomized traffic against a vector-level model.
module tb_operand_packer;
    localparam int W = 16;
    localparam int L = 128;
`ifdef OPERAND_PACKER_PAD_EN
    localparam bit PAD = 1'b1;
`else
    localparam bit PAD = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    operand_packer_if #(.W(W), .L(L)) pk_if ();

    operand_packer #(.W(W), .L(L)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (pk_if)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: a vector being filled or held, its word count, lane contents and bias.
    bit           m_hold;
    int           m_count;
    logic [W-1:0] m_lane [L];
    logic [W-1:0] m_bias;
    int           m_vectors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_hold  = 1'b0;
        m_count = 0;
        m_bias  = '0;
        for (int i = 0; i < L; i++) m_lane[i] = '0;
    endtask

    task automatic model_update();
        if (pk_if.clear) begin
            m_hold  = 1'b0;
            m_count = 0;
        end else if (!m_hold) begin
            if (pk_if.bias_load) m_bias = pk_if.bias_in;
            if (pk_if.in_valid) begin
                m_lane[m_count] = pk_if.in_data;
                if (PAD && pk_if.in_last) begin
                    for (int k = m_count + 1; k < L; k++) m_lane[k] = '0;
                    m_hold = 1'b1;
                end
                m_count++;
                if (m_count == L) m_hold = 1'b1;
            end
        end else if (pk_if.out_ready) begin
            m_vectors++;
            $display("vector %0d handed off: words=%0d lane0=%h bias=%h",
                     m_vectors, m_count, m_lane[0], m_bias);
            m_hold  = 1'b0;
            m_count = 0;
        end
    endtask

    function automatic logic [W-1:0] dut_lane(input int i);
        return pk_if.A_out[i*W +: W];
    endfunction

    task automatic compare_all();
        int bad;
        chk("in_ready",      pk_if.in_ready,      !m_hold);
        chk("out_valid",     pk_if.out_valid,     m_hold);
        chk("en_adder_tree", pk_if.en_adder_tree, m_hold);
        chk("fill_count",    pk_if.fill_count,    m_count);
        chk("Bias_out",      pk_if.Bias_out,      m_bias);
        bad = -1;
        for (int i = 0; i < L; i++)
            if (bad < 0 && dut_lane(i) !== m_lane[i]) bad = i;
        if (bad < 0) bad = 0;
        chk($sformatf("A_out[%0d]", bad), dut_lane(bad), m_lane[bad]);
    endtask

    task automatic step();
        @(posedge clk);
        if (rst_n) model_update();
        #1;
        compare_all();
    endtask

    task automatic idle();
        pk_if.clear     = 1'b0;
        pk_if.in_valid  = 1'b0;
        pk_if.in_data   = '0;
        pk_if.in_last   = 1'b0;
        pk_if.bias_load = 1'b0;
        pk_if.bias_in   = '0;
        pk_if.out_ready = 1'b0;
    endtask

    task automatic fill_words(input int n, input logic [W-1:0] base);
        for (int j = 0; j < n; j++) begin
            pk_if.in_valid = 1'b1;
            pk_if.in_data  = base + W'(j);
            step();
        end
        pk_if.in_valid = 1'b0;
    endtask

    task automatic drain();
        pk_if.out_ready = 1'b1;
        step();
        pk_if.out_ready = 1'b0;
    endtask

    initial begin
        int cycles;
        int start_vec;
        idle();
        model_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        compare_all();
        chk("rst_out_valid", pk_if.out_valid, 1'b0);
        chk("rst_fill", pk_if.fill_count, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", pk_if.in_ready, 1'b1);

        // 1: stream 1..128 with a bias load on the first word
        for (int j = 0; j < L; j++) begin
            pk_if.in_valid  = 1'b1;
            pk_if.in_data   = W'(j + 1);
            pk_if.bias_load = (j == 0);
            pk_if.bias_in   = 16'h0010;
            if (j == L - 1) chk("t1_pre_final_valid", pk_if.out_valid, 1'b0);
            step();
        end
        idle();
        chk("t1_out_valid", pk_if.out_valid, 1'b1);
        chk("t1_lane0", dut_lane(0), 16'h0001);
        chk("t1_lane127", dut_lane(L - 1), 16'h0080);
        chk("t1_bias", pk_if.Bias_out, 16'h0010);

        // 2: back-pressure during HOLD, then hand-off and restart at lane 0
        pk_if.in_valid = 1'b1;
        pk_if.in_data  = 16'hAAAA;
        repeat (20) step();
        chk("t2_in_ready_held", pk_if.in_ready, 1'b0);
        chk("t2_lane3_stable", dut_lane(3), 16'h0004);
        pk_if.out_ready = 1'b1;
        step();
        pk_if.out_ready = 1'b0;
        chk("t2_valid_dropped", pk_if.out_valid, 1'b0);
        chk("t2_fill_zero", pk_if.fill_count, 0);
        step();
        chk("t2_first_word", dut_lane(0), 16'hAAAA);
        chk("t2_fill_one", pk_if.fill_count, 1);
        fill_words(L - 1, 16'h2001);
        chk("t2_lane1", dut_lane(1), 16'h2001);
        drain();

        // 3: clear after 50 words, then a fresh vector
        fill_words(50, 16'h3000);
        pk_if.clear = 1'b1;
        step();
        pk_if.clear = 1'b0;
        chk("t3_fill_cleared", pk_if.fill_count, 0);
        chk("t3_no_valid", pk_if.out_valid, 1'b0);
        fill_words(L, 16'h0100);
        chk("t3_valid", pk_if.out_valid, 1'b1);
        chk("t3_lane0", dut_lane(0), 16'h0100);
        chk("t3_lane49", dut_lane(49), 16'h0131);
        chk("t3_lane127", dut_lane(L - 1), 16'h017F);
        drain();

        // 4: asynchronous reset while holding a vector
        fill_words(L, 16'h5000);
        chk("t4_holding", pk_if.out_valid, 1'b1);
        rst_n = 1'b0;
        model_reset();
        #2;
        compare_all();
        chk("t4_valid_low", pk_if.out_valid, 1'b0);
        chk("t4_lane5_zero", dut_lane(5), 16'h0000);
        chk("t4_bias_zero", pk_if.Bias_out, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("t4_in_ready", pk_if.in_ready, 1'b1);

`ifdef OPERAND_PACKER_PAD_EN
        // 5: short vector terminated by in_last zeroes the upper lanes
        fill_words(L, 16'hFFF0);
        drain();
        for (int j = 0; j < 3; j++) begin
            pk_if.in_valid = 1'b1;
            pk_if.in_data  = W'(j + 1);
            pk_if.in_last  = (j == 2);
            step();
        end
        idle();
        chk("t5_valid", pk_if.out_valid, 1'b1);
        chk("t5_fill", pk_if.fill_count, 3);
        chk("t5_lane2", dut_lane(2), 16'h0003);
        chk("t5_lane3", dut_lane(3), 16'h0000);
        chk("t5_lane127", dut_lane(L - 1), 16'h0000);
        drain();
`endif

        // 6: randomized traffic
        start_vec = m_vectors;
        cycles = 0;
        while ((m_vectors - start_vec) < 150 && cycles < 60000) begin
            pk_if.in_valid  = ($urandom_range(0, 9) < 8);
            pk_if.in_data   = W'($urandom);
            pk_if.in_last   = ($urandom_range(0, 63) == 0);
            pk_if.bias_load = ($urandom_range(0, 19) == 0);
            pk_if.bias_in   = W'($urandom);
            pk_if.out_ready = $urandom_range(0, 1);
            pk_if.clear     = ($urandom_range(0, 499) == 0);
            step();
            cycles++;
        end
        idle();
        chk("t6_vectors_done", ((m_vectors - start_vec) >= 150), 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
